micro_sequencer: RTL and testbench
==================================

// Module: micro_sequencer
// PURPOSE
//  Microcode sequencer for the multicycle core; sits directly upstream of the control-store ROM.
//  Holds the 5-bit micro-PC (state), dispatches on the instruction opcode and drives adr to the ROM.
//  The ROM returns one 17-bit control word per state, combinationally, in the same cycle.
//  Also stalls on memory, idles on halt, flags illegal opcodes and counts retired instructions.
// PARAMETERS
//  CNT_W        16   width of retired-instruction counter (wraps)
//  MEM_WAIT_EN  1    1: memory states wait for mem_ready; 0: mem_ready ignored (treated as 1)
// PORTS
//  clk          in   1      single clock, all state updates on rising edge
//  reset        in   1      synchronous, active-high
//  op           in   7      opcode field of instruction register (valid from DECODE onward)
//  mem_ready    in   1      memory access completes this cycle
//  halt         in   1      request to idle in FETCH
//  adr          out  5      micro-PC to ROM = registered state
//  retire       out  1      1-cycle pulse: an instruction completed this cycle
//  illegal_op   out  1      sticky: undecodable opcode seen in DECODE
//  instr_count  out  CNT_W  number of retire pulses since reset, modulo 2^CNT_W
// BEHAVIOUR
//  Reset (sync, high): state=FETCH(0), op_q=0, illegal_op=0, instr_count=0, retire=0.
//  Reset has priority over every other input and aborts any state mid-instruction.
//  States / codes: FETCH=0 DECODE=1 MEMADR=2 MEMREAD=3 MEMWB=4 MEMWRITE=5
//   EXECUTER=6 EXECUTEI=7 ALUWB=8 BRANCH=9. Codes 10-31 are unreachable; if entered, go to FETCH.
//  Opcodes: LW=0000011 SW=0100011 RTYPE=0110011 ITYPE=0010011 BEQ=1100011.
//  rdy = mem_ready | ~MEM_WAIT_EN.
//  Transitions (evaluated each rising edge):
//   FETCH   : halt -> FETCH; else rdy -> DECODE; else FETCH.
//   DECODE  : op_q<=op; LW/SW -> MEMADR; RTYPE -> EXECUTER; ITYPE -> EXECUTEI; BEQ -> BRANCH;
//             any other op -> FETCH and set illegal_op (no retire).
//   MEMADR  : op_q==LW -> MEMREAD; otherwise (SW) -> MEMWRITE.
//   MEMREAD : rdy -> MEMWB; else hold.
//   MEMWB   : -> FETCH, retire.
//   MEMWRITE: rdy -> FETCH, retire; else hold.
//   EXECUTER/EXECUTEI -> ALUWB.
//   ALUWB   : -> FETCH, retire.
//   BRANCH  : -> FETCH, retire.
//  Halt: sampled only in FETCH; an instruction in flight always completes before idling.
//  op_q: written only in DECODE; MEMADR dispatch uses op_q, never the live op.
//  retire: registered; high for exactly the one cycle after the completing edge, i.e. the first
//   cycle back in FETCH. instr_count increments on that same edge.
//  instr_count: wraps 2^CNT_W-1 -> 0 with no flag.
//  illegal_op: cleared only by reset.
//  Latency: adr is valid straight from the flop; the ROM word follows combinationally.
//  Cycles per instruction with mem_ready=1 (fetch counted): LW 5, SW 4, R/I 4, BEQ 3.
// STRUCTURE
//  Shared package mc_pkg:
//   - state_t enum (5-bit, codes above), shared with the ROM and its decoder;
//   - opcode localparams OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ.
//  One sub-module opcode_dispatch: combinational; op -> {next state, illegal}, used in DECODE.
//  Remainder: state register, op_q register, retire/count/sticky flags in this module.
// TESTING
//  1 reset mid-MEMREAD (mem_ready=0) -> next cycle adr=0, instr_count=0, illegal_op=0.
//  2 LW, mem_ready=1 -> adr 0,1,2,3,4,0; retire pulses once; instr_count 0->1.
//  3 SW with mem_ready low 3 cycles in MEMWRITE -> adr 0,1,2,5,5,5,5,0; one retire.
//  4 op=1111111 in DECODE -> adr 0,1,0; illegal_op=1 and stays 1; no retire; count unchanged.
//  5 halt=1 asserted during EXECUTER -> ALUWB, FETCH, then adr stays 0; resumes DECODE 1 cycle after halt=0.
//  6 CNT_W=4, 16 back-to-back BEQs -> instr_count wraps 15->0; op changed in MEMADR ignored (op_q).

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the micro-sequencer, its opcode decoder and the control-store ROM.
package mc_pkg;

  // Micro-PC encoding; these codes are the control-store ROM addresses.
  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_MEMADR   = 5'd2,
    S_MEMREAD  = 5'd3,
    S_MEMWB    = 5'd4,
    S_MEMWRITE = 5'd5,
    S_EXECUTER = 5'd6,
    S_EXECUTEI = 5'd7,
    S_ALUWB    = 5'd8,
    S_BRANCH   = 5'd9
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

endpackage

// File: rtl/micro_sequencer_opcode_dispatch.sv
// Combinational opcode decode: picks the state that follows DECODE and flags unknown opcodes.
module opcode_dispatch
  import mc_pkg::*;
(
  input  logic [6:0] op_i,
  output state_t     next_state_o,
  output logic       illegal_o
);

  // Map the opcode to its first execution state; anything unknown returns to FETCH.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    next_state_o = S_FETCH;
    illegal_o    = 1'b0;
    case (op_i)
      OP_LW, OP_SW: next_state_o = S_MEMADR;
      OP_RTYPE:     next_state_o = S_EXECUTER;
      OP_ITYPE:     next_state_o = S_EXECUTEI;
      OP_BEQ:       next_state_o = S_BRANCH;
      default:      illegal_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microcode sequencer: holds the micro-PC driven to the control-store ROM, dispatches on the
// opcode, waits on memory, idles on halt, flags illegal opcodes and counts retired instructions.
module micro_sequencer
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter bit          MEM_WAIT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic             mem_ready,
  input  logic             halt,
  output logic [4:0]       adr,
  output logic             retire,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic             retire_q, retire_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q;
  state_t           disp_state;
  logic             disp_illegal;
  logic             rdy;

  // With waiting disabled, memory is treated as always ready.
  assign rdy = mem_ready | ~MEM_WAIT_EN;

  opcode_dispatch u_dispatch (
    .op_i         (op),
    .next_state_o (disp_state),
    .illegal_o    (disp_illegal)
  );

  // Next-state logic: micro-PC transitions, op latch in DECODE, retire and illegal flag updates.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    retire_d  = 1'b0;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH: begin
        if (!halt && rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d    = op;
        state_d = disp_state;
        if (disp_illegal) illegal_d = 1'b1;
      end
      S_MEMADR:   state_d = (op_q == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        state_d  = S_FETCH;
        retire_d = 1'b1;
      end
      S_MEMWRITE: begin
        if (rdy) begin
          state_d  = S_FETCH;
          retire_d = 1'b1;
        end
      end
      S_EXECUTER, S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB, S_BRANCH: begin
        state_d  = S_FETCH;
        retire_d = 1'b1;
      end
      default:    state_d = S_FETCH;  // unreachable codes recover to FETCH
    endcase
  end

  // State register with synchronous reset; the counter steps on the same edge retire rises.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retire_q  <= retire_d;
      illegal_q <= illegal_d;
      if (retire_d) count_q <= count_q + 1'b1;
    end
  end

  assign adr         = state_q;
  assign retire      = retire_q;
  assign illegal_op  = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: one default instance and one with a 4-bit counter share stimulus.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic        mem_ready;
  logic        halt;
  logic [4:0]  adr, adr_s;
  logic        retire, retire_s;
  logic        illegal_op, illegal_s;
  logic [15:0] instr_count;
  logic [3:0]  count_s;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  micro_sequencer dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready), .halt(halt),
    .adr(adr), .retire(retire), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  micro_sequencer #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready), .halt(halt),
    .adr(adr_s), .retire(retire_s), .illegal_op(illegal_s), .instr_count(count_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_adr(input string tag, input logic [4:0] exp);
    step();
    check(tag, {27'd0, adr}, {27'd0, exp});
  endtask

  initial begin
    reset = 1'b1; op = 7'd0; mem_ready = 1'b1; halt = 1'b1;
    step(); step();
    reset = 1'b0;
    step();

    // 1: reset aborts an LW stalled in MEMREAD.
    op = 7'b0000011; halt = 1'b0; mem_ready = 1'b1;
    step_adr("t1_decode", 5'd1);
    halt = 1'b1;
    step_adr("t1_memadr", 5'd2);
    mem_ready = 1'b0;
    step_adr("t1_memread", 5'd3);
    step_adr("t1_memread_hold", 5'd3);
    reset = 1'b1;
    step_adr("t1_reset_adr", 5'd0);
    check("t1_reset_count", {16'd0, instr_count}, 32'd0);
    check("t1_reset_illegal", {31'd0, illegal_op}, 32'd0);
    check("t1_reset_retire", {31'd0, retire}, 32'd0);
    reset = 1'b0; mem_ready = 1'b1;
    step_adr("t1_idle", 5'd0);

    // 2: LW with memory always ready.
    op = 7'b0000011; halt = 1'b0;
    step_adr("t2_a1", 5'd1);
    halt = 1'b1;
    step_adr("t2_a2", 5'd2);
    step_adr("t2_a3", 5'd3);
    check("t2_no_retire", {31'd0, retire}, 32'd0);
    step_adr("t2_a4", 5'd4);
    step_adr("t2_a0", 5'd0);
    check("t2_retire", {31'd0, retire}, 32'd1);
    check("t2_count", {16'd0, instr_count}, 32'd1);
    step_adr("t2_idle", 5'd0);
    check("t2_retire_pulse", {31'd0, retire}, 32'd0);

    // 3: SW with mem_ready low for three cycles in MEMWRITE.
    op = 7'b0100011; halt = 1'b0;
    step_adr("t3_a1", 5'd1);
    halt = 1'b1;
    step_adr("t3_a2", 5'd2);
    mem_ready = 1'b0;
    step_adr("t3_a5", 5'd5);
    for (int i = 0; i < 3; i++) begin
      step_adr("t3_hold", 5'd5);
      check("t3_hold_retire", {31'd0, retire}, 32'd0);
    end
    mem_ready = 1'b1;
    step_adr("t3_a0", 5'd0);
    check("t3_retire", {31'd0, retire}, 32'd1);
    check("t3_count", {16'd0, instr_count}, 32'd2);

    // 4: undecodable opcode.
    op = 7'b1111111; halt = 1'b0;
    step_adr("t4_a1", 5'd1);
    check("t4_illegal_before", {31'd0, illegal_op}, 32'd0);
    halt = 1'b1;
    step_adr("t4_a0", 5'd0);
    check("t4_illegal", {31'd0, illegal_op}, 32'd1);
    check("t4_no_retire", {31'd0, retire}, 32'd0);
    check("t4_count", {16'd0, instr_count}, 32'd2);
    step_adr("t4_idle", 5'd0);
    check("t4_sticky", {31'd0, illegal_op}, 32'd1);

    // 5: halt raised during EXECUTER; instruction still completes, then idles.
    op = 7'b0110011; halt = 1'b0;
    step_adr("t5_a1", 5'd1);
    step_adr("t5_a6", 5'd6);
    halt = 1'b1;
    step_adr("t5_a8", 5'd8);
    step_adr("t5_a0", 5'd0);
    check("t5_retire", {31'd0, retire}, 32'd1);
    check("t5_count", {16'd0, instr_count}, 32'd3);
    step_adr("t5_halt0", 5'd0);
    step_adr("t5_halt1", 5'd0);
    halt = 1'b0; op = 7'b0010011;
    step_adr("t5_resume", 5'd1);
    halt = 1'b1;
    step_adr("t5_a7", 5'd7);
    step_adr("t5_a8b", 5'd8);
    step_adr("t5_a0b", 5'd0);
    check("t5_count_i", {16'd0, instr_count}, 32'd4);

    // 6a: op changed while in MEMADR is ignored; dispatch uses the latched LW.
    op = 7'b0000011; halt = 1'b0;
    step_adr("t6_a1", 5'd1);
    halt = 1'b1;
    step_adr("t6_a2", 5'd2);
    op = 7'b0100011;
    step_adr("t6_memread", 5'd3);
    step_adr("t6_a4", 5'd4);
    step_adr("t6_a0", 5'd0);
    check("t6_count", {16'd0, instr_count}, 32'd5);
    check("t6_small_count", {28'd0, count_s}, 32'd5);

    // 6b: 16 back-to-back BEQs; the 4-bit counter wraps 15 -> 0.
    op = 7'b1100011; halt = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step_adr("t6_beq_decode", 5'd1);
      step_adr("t6_beq_branch", 5'd9);
      if (k == 16) halt = 1'b1;
      step_adr("t6_beq_fetch", 5'd0);
      check("t6_beq_retire", {31'd0, retire}, 32'd1);
      check("t6_beq_count", {16'd0, instr_count}, 32'(5 + k));
      check("t6_beq_small", {28'd0, count_s}, 32'((5 + k) % 16));
    end
    step_adr("t6_idle", 5'd0);
    check("t6_illegal_still", {31'd0, illegal_op}, 32'd1);

    // Final reset clears the sticky flag and both counters.
    reset = 1'b1;
    step();
    check("end_illegal", {31'd0, illegal_op}, 32'd0);
    check("end_count", {16'd0, instr_count}, 32'd0);
    check("end_small", {28'd0, count_s}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
